// File: rtl/led_show_arbiter_pkg.sv
// Shared encodings for the LED show arbiter: display modes and sequencer states.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_RSVD   = 2'd3
    } led_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_FIN  = 2'd2
    } led_state_e;

endpackage

// File: rtl/led_show_arbiter_tick_gen.sv
// Free-running prescaler; tick is a one-cycle enable each time the counter hits all-ones.
module led_tick_gen #(
    parameter int TICK_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    logic [TICK_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = &cnt_q;

endmodule

// File: rtl/led_show_arbiter.sv
// Round-robin owner of the user LEDs; animates the winner's pattern for a fixed
// number of prescaled ticks, then hands the bank back.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | LEDs dark, scanning requests from rr_ptr+1 for the next owner
//   ST_SHOW | owner holds the LEDs; mode applied on every tick
//   ST_FIN  | one-cycle release, done pulsed to the owner
module led_show_arbiter
    import led_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LED_W      = 8,
    parameter int TICK_W     = 20,
    parameter int HOLD_TICKS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [2*NUM_REQ-1:0]     mode,
    input  logic [LED_W*NUM_REQ-1:0] pattern,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [LED_W-1:0]         leds
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    led_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic [LED_W-1:0]   leds_q, leds_d;
    logic [7:0]         hold_q, hold_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    led_mode_e          mode_q, mode_d;
    logic [LED_W-1:0]   pat_q, pat_d;

    logic               tick;
    logic               tick_clr;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic [LED_W-1:0]   leds_anim;
    logic [7:0]         hold_inc;

    led_tick_gen #(
        .TICK_W (TICK_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    // First requester strictly after the last owner, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_q) + i) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        leds_anim = leds_q;
        case (mode_q)
            MODE_CHASE: leds_anim = {leds_q[LED_W-2:0], leds_q[LED_W-1]};
            MODE_BLINK: leds_anim = (leds_q == pat_q) ? '0 : pat_q;
            default:    leds_anim = leds_q;
        endcase
    end

    assign hold_inc = hold_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        leds_d   = leds_q;
        hold_d   = hold_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        mode_d   = mode_q;
        pat_d    = pat_q;
        tick_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                leds_d  = '0;
                if (win_found) begin
                    state_d          = ST_SHOW;
                    grant_d[win_idx] = 1'b1;
                    owner_d          = win_idx;
                    mode_d           = led_mode_e'(mode[2*win_idx +: 2]);
                    pat_d            = pattern[LED_W*win_idx +: LED_W];
                    leds_d           = pattern[LED_W*win_idx +: LED_W];
                    hold_d           = '0;
                    tick_clr         = 1'b1;
                end
            end
            ST_SHOW: begin
                // A dropped request wins over a completion landing in the same cycle.
                if (!req[owner_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    leds_d  = '0;
                    rr_d    = owner_q;
                end else if (tick) begin
                    hold_d = hold_inc;
                    if (hold_inc == 8'(HOLD_TICKS)) begin
                        state_d         = ST_FIN;
                        grant_d         = '0;
                        leds_d          = '0;
                        done_d[owner_q] = 1'b1;
                        rr_d            = owner_q;
                    end else begin
                        leds_d = leds_anim;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                leds_d  = '0;
            end
        endcase

        busy_d = (state_d == ST_SHOW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            leds_q  <= '0;
            hold_q  <= '0;
            rr_q    <= IDX_W'(NUM_REQ - 1);
            owner_q <= '0;
            mode_q  <= MODE_STATIC;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            leds_q  <= leds_d;
            hold_q  <= hold_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            mode_q  <= mode_d;
            pat_q   <= pat_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign leds  = leds_q;

endmodule

// File: tb/tb_led_show_arbiter.sv
// Scoreboard bench: each output change is matched against a queue of expected
// output vectors, including the number of cycles since the previous change.
module tb_led_show_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int LED_W      = 8;
    localparam int TICK_W     = 2;
    localparam int HOLD_TICKS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [7:0]  mode = '0;
    logic [31:0] pattern = '0;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [7:0]  leds;

    always #5 clk = ~clk;

    led_show_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .LED_W      (LED_W),
        .TICK_W     (TICK_W),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .mode    (mode),
        .pattern (pattern),
        .grant   (grant),
        .done    (done),
        .busy    (busy),
        .leds    (leds)
    );

    typedef struct {
        logic [3:0] grant;
        logic [7:0] leds;
        logic [3:0] done;
        logic       busy;
        int         gap;   // cycles since previous change; -1 = don't care
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    function automatic void push(logic [3:0] g, logic [7:0] l, logic [3:0] d, logic b, int gap);
        exp_t e;
        e.grant = g; e.leds = l; e.done = d; e.busy = b; e.gap = gap;
        exp_q.push_back(e);
    endfunction

    task automatic tick_wait(int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic cfg(int idx, logic [1:0] m, logic [7:0] p);
        mode[2*idx +: 2]    = m;
        pattern[8*idx +: 8] = p;
    endtask

    task automatic check_zero(string name);
        checks++;
        if ({grant, leds, done, busy} !== 17'd0) begin
            failures++;
            $display("FAIL %s: grant=%b leds=%h done=%b busy=%b, required all zero",
                     name, grant, leds, done, busy);
        end
    endtask

    // Monitor: any change of the output vector pops and checks one expectation.
    initial begin
        logic [16:0] prev;
        logic [16:0] cur;
        logic [16:0] want;
        int          n;
        int          last;
        exp_t        e;
        n = 0;
        last = 0;
        wait (mon_en);
        @(negedge clk);
        prev = {grant, leds, done, busy};
        forever begin
            @(negedge clk);
            n++;
            cur = {grant, leds, done, busy};
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change: grant=%b leds=%h done=%b busy=%b, required no change",
                             grant, leds, done, busy);
                end else begin
                    e = exp_q.pop_front();
                    want = {e.grant, e.leds, e.done, e.busy};
                    if (cur !== want || (e.gap >= 0 && (n - last) != e.gap)) begin
                        failures++;
                        $display("FAIL output_event: got grant=%b leds=%h done=%b busy=%b gap=%0d, required grant=%b leds=%h done=%b busy=%b gap=%0d",
                                 grant, leds, done, busy, n - last,
                                 e.grant, e.leds, e.done, e.busy, e.gap);
                    end
                end
                last = n;
            end
            prev = cur;
        end
    end

    initial begin
        // 1: reset, then idle with no requests
        rst = 1'b1;
        req = '0;
        tick_wait(3);
        check_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick_wait(1);
            check_zero("idle_after_reset");
        end
        mon_en = 1'b1;
        tick_wait(3);

        // 2: STATIC A5 for 12 cycles, FIN with done, then idle
        cfg(0, 2'd0, 8'hA5);
        push(4'b0001, 8'hA5, 4'b0000, 1'b1, -1);
        push(4'b0000, 8'h00, 4'b0001, 1'b0, 12);
        push(4'b0000, 8'h00, 4'b0000, 1'b0, 1);
        req = 4'b0001;
        tick_wait(13);
        req = '0;
        tick_wait(6);

        // 3: CHASE 81 -> 03 -> 06
        cfg(0, 2'd1, 8'h81);
        push(4'b0001, 8'h81, 4'b0000, 1'b1, -1);
        push(4'b0001, 8'h03, 4'b0000, 1'b1, 4);
        push(4'b0001, 8'h06, 4'b0000, 1'b1, 4);
        push(4'b0000, 8'h00, 4'b0001, 1'b0, 4);
        push(4'b0000, 8'h00, 4'b0000, 1'b0, 1);
        req = 4'b0001;
        tick_wait(13);
        req = '0;
        tick_wait(6);

        // 4: BLINK 3C -> 00 -> 3C -> release
        cfg(0, 2'd2, 8'h3C);
        push(4'b0001, 8'h3C, 4'b0000, 1'b1, -1);
        push(4'b0001, 8'h00, 4'b0000, 1'b1, 4);
        push(4'b0001, 8'h3C, 4'b0000, 1'b1, 4);
        push(4'b0000, 8'h00, 4'b0001, 1'b0, 4);
        push(4'b0000, 8'h00, 4'b0000, 1'b0, 1);
        req = 4'b0001;
        tick_wait(13);
        req = '0;
        tick_wait(6);

        // 5: all requesting from reset: round robin 0,1,2,3,0 with 2-cycle gaps
        rst = 1'b1;
        req = 4'b1111;
        cfg(0, 2'd0, 8'h11);
        cfg(1, 2'd0, 8'h22);
        cfg(2, 2'd0, 8'h44);
        cfg(3, 2'd3, 8'h88);
        tick_wait(2);
        for (int k = 0; k < 4; k++) begin
            push(4'(1 << k), 8'(8'h11 << k), 4'b0000, 1'b1, (k == 0) ? -1 : 1);
            push(4'b0000, 8'h00, 4'(1 << k), 1'b0, 12);
            push(4'b0000, 8'h00, 4'b0000, 1'b0, 1);
        end
        push(4'b0001, 8'h11, 4'b0000, 1'b1, 1);
        push(4'b0000, 8'h00, 4'b0000, 1'b0, 3);
        rst = 1'b0;
        tick_wait(59);
        req = '0;
        tick_wait(5);

        // 6a: owner drops its request 5 cycles into the show: no done
        cfg(0, 2'd0, 8'h5A);
        push(4'b0001, 8'h5A, 4'b0000, 1'b1, -1);
        push(4'b0000, 8'h00, 4'b0000, 1'b0, 5);
        req = 4'b0001;
        tick_wait(5);
        req = '0;
        tick_wait(5);

        // 6b: reset mid-show
        cfg(0, 2'd1, 8'h0F);
        push(4'b0001, 8'h0F, 4'b0000, 1'b1, -1);
        push(4'b0001, 8'h1E, 4'b0000, 1'b1, 4);
        push(4'b0000, 8'h00, 4'b0000, 1'b0, 2);
        req = 4'b0001;
        tick_wait(6);
        rst = 1'b1;
        tick_wait(1);
        check_zero("reset_mid_show");
        req = '0;
        tick_wait(1);
        rst = 1'b0;
        tick_wait(3);

        // rr pointer back to NUM_REQ-1 after reset: requester 0 beats 3
        push(4'b0001, 8'h0F, 4'b0000, 1'b1, -1);
        push(4'b0000, 8'h00, 4'b0000, 1'b0, 2);
        req = 4'b1001;
        tick_wait(2);
        req = '0;
        tick_wait(6);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick_wait(1);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events: %0d expected output changes never seen, required 0",
                     exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
